// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 32-bit MIPS pipeline.
//
// Owns the PC, issues word fetches over a req/ack handshake that tolerates any
// memory latency, and holds up to BUF_DEPTH returned instructions. The oldest
// entry is presented to the IF/ID registers. Stall holds the head entry.
// Redirect flushes the buffer and restarts fetching at the new target.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request, held until imem_ack
//   imem_addr    word-aligned fetch address, stable while imem_req=1
//   imem_ack     memory accepts the request and drives imem_rdata this cycle
//   imem_rdata   instruction word, valid only with imem_ack
//   stall        IF/ID holds; the head entry is not consumed
//   redirect     branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc  redirect target, bits [1:0] ignored
//   if_valid     if_instr/if_pc hold a real instruction
//   if_instr     head instruction, 0 (NOP) when if_valid=0
//   if_pc        PC of the head instruction
//   if_pc_plus4  if_pc + 4, mod 2^32

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {StIdle, StReq, StReqDiscard} state_e;

    state_e        state_q;
    logic          req_q;
    logic [31:0]   addr_q;      // address of the outstanding request
    logic [31:0]   fetch_pc_q;  // next PC to fetch (redirect target while discarding)

    logic [31:0]   pc_mem    [BUF_DEPTH];
    logic [31:0]   instr_mem [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          head_valid;
    logic          push;
    logic          pop;
    logic          space_now;
    logic          space_after_push;
    logic [CW-1:0] occ_after_pop;
    logic [31:0]   target_pc;
    logic [31:0]   next_seq_pc;

    always_comb begin
        target_pc        = redirect_pc & 32'hFFFF_FFFC;
        next_seq_pc      = fetch_pc_q + 32'd4;
        head_valid       = (count_q != '0);
        pop              = head_valid & ~stall & ~redirect;
        push             = (state_q == StReq) & imem_ack & ~redirect;
        // Occupancy once this cycle's pop has happened; pop implies count >= 1.
        occ_after_pop    = count_q - CW'(pop);
        space_now        = (occ_after_pop < CW'(BUF_DEPTH));
        space_after_push = ((occ_after_pop + CW'(1)) < CW'(BUF_DEPTH));
    end

    // Buffer storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            addr_q     <= START_PC;
            fetch_pc_q <= START_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end

            unique case (state_q)
                StIdle: begin
                    if (redirect) begin
                        fetch_pc_q <= target_pc;
                    end else if (space_now) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (redirect) begin
                        fetch_pc_q <= target_pc;
                        if (imem_ack) begin
                            // Request completed and dropped; buffer is empty, so refetch now.
                            addr_q <= target_pc;
                        end else begin
                            // Keep the old address on the bus until the memory answers.
                            state_q <= StReqDiscard;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_q <= next_seq_pc;
                        if (space_after_push) begin
                            addr_q <= next_seq_pc;
                        end else begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end
                    end
                end
                StReqDiscard: begin
                    if (redirect) fetch_pc_q <= target_pc;
                    if (imem_ack) begin
                        state_q <= StReq;
                        addr_q  <= redirect ? target_pc : fetch_pc_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_valid    = head_valid;
    assign if_instr    = head_valid ? instr_mem[rd_ptr_q] : 32'h0000_0000;
    assign if_pc       = head_valid ? pc_mem[rd_ptr_q] : fetch_pc_q;
    assign if_pc_plus4 = if_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order scoreboard (consumed PCs must be sequential from the
// last reset/redirect target, each carrying the word the memory returned).

module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    // Second instance near the top of the address space, acked every cycle.
    logic        rst2_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    assign w_ack   = w_req;
    assign w_rdata = w_addr ^ KEY;

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_w (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0000_0000),
        .if_valid(w_valid), .if_instr(w_instr),
        .if_pc(w_pc), .if_pc_plus4(w_pc4)
    );

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse released between clock edges.
    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %h want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h want 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        checks++; if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h want 4", if_pc_plus4); end
        checks++; if (w_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_w_pc: got %h want fffffff8", w_pc); end
        checks++; if (w_pc4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_w_pc4: got %h want fffffffc", w_pc4); end
        checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL reset_w_req: got %h want 0", w_req); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %h want 1", k, imem_req); end
            checks++; if (imem_addr !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * (k - 1))); end
            if (k == 1) begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %h want 0", if_valid); end
            end else begin
                exp = 32'(4 * (k - 2));
                checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %h want 1", k, if_valid); end
                checks++; if (if_pc !== exp) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, if_pc, exp); end
                checks++; if (if_pc_plus4 !== exp + 32'd4) begin errors++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, if_pc_plus4, exp + 32'd4); end
                checks++; if (if_instr !== (exp ^ KEY)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, if_instr, exp ^ KEY); end
            end
            imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_stall();
        int acks;
        logic [31:0] exp;
        do_reset();
        tick();
        imem_ack = imem_req; imem_rdata = imem_addr ^ KEY;
        acks = imem_req ? 1 : 0;
        tick();
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_first_valid: got %h want 1", if_valid); end
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            imem_ack = imem_req; imem_rdata = imem_addr ^ KEY;
            if (imem_req) acks++;
            tick();
            checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL stall_hold_pc[%0d]: got %h want 0", i, if_pc); end
        end
        imem_ack = 1'b0;
        checks++; if (acks != 2) begin errors++; $display("FAIL stall_accepted: got %0d want 2", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_drop: got %h want 0", imem_req); end
        stall = 1'b0;
        exp = 32'h0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid[%0d]: got %h want 1", i, if_valid); end
            checks++; if (if_pc !== exp) begin errors++; $display("FAIL stall_release_pc[%0d]: got %h want %h", i, if_pc, exp); end
            exp += 32'd4;
            imem_ack = imem_req; imem_rdata = imem_addr ^ KEY;
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_redirect_latency();
        do_reset();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL lat_first_req: got req %h addr %h want 1/0", imem_req, imem_addr); end
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_1003;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL lat_addr_held: got %h want 0", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req_held: got %h want 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL lat_discard_valid: got %h want 0", if_valid); end
        checks++; if (imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lat_new_addr: got %h want 00001000", imem_addr); end
        imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY;
        tick();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_1000) begin errors++; $display("FAIL lat_first_pc: got valid %h pc %h want 1/00001000", if_valid, if_pc); end
        checks++; if (if_instr !== (32'h0000_1000 ^ KEY)) begin errors++; $display("FAIL lat_first_instr: got %h want %h", if_instr, 32'h0000_1000 ^ KEY); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        tick();
        imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hBAD1_1111;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdack_valid: got %h want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rdack_addr: got req %h addr %h want 1/00000200", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY;
        tick();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_0200) begin errors++; $display("FAIL rdack_pc: got valid %h pc %h want 1/00000200", if_valid, if_pc); end
    endtask

    task automatic test_wrap();
        int waited;
        rst2_n = 1'b1;
        waited = 0;
        while (w_valid !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_timeout: got %h want 1", w_valid); end
        checks++; if (w_pc !== 32'hFFFF_FFF8 || w_pc4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h/%h want fffffff8/fffffffc", w_pc, w_pc4); end
        tick();
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %h want fffffffc", w_pc); end
        checks++; if (w_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", w_pc4); end
        tick();
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc2: got valid %h pc %h want 1/0", w_valid, w_pc); end
        rst2_n = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY;
        tick();
        // Late ack for the request that reset is about to drop.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL areset_req: got %h want 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %h want 0", if_valid); end
        tick();
        #2 rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset_restart: got req %h addr %h want 1/0", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_late_ack: got %h want 0", if_valid); end
        imem_ack = 1'b1; imem_rdata = imem_addr ^ KEY;
        tick();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== KEY) begin errors++; $display("FAIL areset_first: got valid %h pc %h instr %h want 1/0/%h", if_valid, if_pc, if_instr, KEY); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic        pend;
        logic        after_redirect;
        int          pops;
        do_reset();
        exp_pc = 32'h0; pend = 1'b0; pend_addr = '0; after_redirect = 1'b0; pops = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (pend) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin errors++; $display("FAIL rnd_req_hold[%0d]: got req %h addr %h want 1/%h", cyc, imem_req, imem_addr, pend_addr); end
            end
            if (after_redirect) begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush[%0d]: got %h want 0", cyc, if_valid); end
            end
            if (if_valid !== 1'b1) begin
                checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rnd_nop[%0d]: got %h want 0", cyc, if_instr); end
            end else begin
                checks++; if (if_pc_plus4 !== if_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4[%0d]: got %h want %h", cyc, if_pc_plus4, if_pc + 32'd4); end
            end
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            imem_ack    = imem_req && ($urandom_range(0, 2) != 0);
            imem_rdata  = imem_ack ? (imem_addr ^ KEY) : $urandom;
            if (if_valid === 1'b1 && !stall && !redirect) begin
                checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", cyc, if_pc, exp_pc); end
                checks++; if (if_instr !== (exp_pc ^ KEY)) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", cyc, if_instr, exp_pc ^ KEY); end
                exp_pc += 32'd4;
                pops++;
            end
            if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            after_redirect = redirect;
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
        end
        stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        checks++; if (pops < 100) begin errors++; $display("FAIL rnd_progress: got %0d pops want >= 100", pops); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
